ps2_code_history: RTL and testbench

//  Parametrised PS/2 scan-code history buffer. It sits between PS2_controller and the hex/7-segment display path.
//  It captures make codes, and optionally break codes, into a DEPTH-byte shift history.

---
 rtl/ps2_code_history.sv | 155 +++++++++++++++
 tb/tb_ps2_code_history.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_code_history.sv
// PS/2 scan-code history buffer.
// Captures make codes (and optionally break codes) into a DEPTH-byte shift
// history. A single-key tracker suppresses typematic repeats. Hold freezes
// the display and counts lost codes. Clear wipes the history and all stats.
module ps2_code_history #(
  parameter int DEPTH         = 3,
  parameter int CAPTURE_BREAK = 0,
  parameter int SUPPRESS_REP  = 1
) (
  input  logic                         Clock_50,
  input  logic                         Resetn,
  input  logic [7:0]                   PS2_code,
  input  logic                         PS2_code_ready,
  input  logic                         PS2_make_code,
  input  logic                         Hold,
  input  logic                         Clear,
  output logic [8*DEPTH-1:0]           History,
  output logic [$clog2(DEPTH+1)-1:0]   Valid_count,
  output logic                         New_code,
  output logic                         Key_down,
  output logic [15:0]                  Event_count,
  output logic [7:0]                   Repeat_count,
  output logic [7:0]                   Drop_count
);

  localparam int HW = 8*DEPTH;
  localparam int VW = $clog2(DEPTH+1);
  localparam logic [VW-1:0] VMAX = VW'(DEPTH);

  typedef enum logic {KEY_UP = 1'b0, KEY_DOWN = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [7:0]      last_key_q, last_key_d;
  logic            ready_buf_q, ready_buf_d;
  logic [HW-1:0]   history_q, history_d, hist_shift;
  logic [VW-1:0]   valid_q, valid_d;
  logic            new_code_q, new_code_d;
  logic [15:0]     event_q, event_d;
  logic [7:0]      repeat_q, repeat_d;
  logic [7:0]      drop_q, drop_d;
  logic            evt, accept, suppress;

  // One event per rising edge of the ready level.
  assign ready_buf_d = PS2_code_ready;
  assign evt         = PS2_code_ready & ~ready_buf_q;

  // Newest byte enters at the bottom; a 1-byte history is simply replaced.
  generate
    if (DEPTH == 1) begin : g_shift1
      assign hist_shift = PS2_code;
    end else begin : g_shiftn
      assign hist_shift = {history_q[HW-9:0], PS2_code};
    end
  endgenerate

  // Tracker state register; ready_buf keeps updating even under Clear.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= KEY_UP;
      last_key_q  <= 8'h00;
      ready_buf_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_key_q  <= last_key_d;
      ready_buf_q <= ready_buf_d;
    end
  end

  // Tracker next state and event classification (accept / suppress / ignore).
  always_comb begin
    state_d    = state_q;
    last_key_d = last_key_q;
    accept     = 1'b0;
    suppress   = 1'b0;
    if (Clear) begin
      state_d    = KEY_UP;
      last_key_d = 8'h00;
    end else if (evt) begin
      if (PS2_make_code) begin
        if (state_q == KEY_DOWN && PS2_code == last_key_q && SUPPRESS_REP != 0) begin
          suppress = 1'b1;
        end else begin
          state_d    = KEY_DOWN;
          last_key_d = PS2_code;
          accept     = 1'b1;
        end
      end else begin
        // Only the break of the tracked key releases it; any break may be stored.
        if (state_q == KEY_DOWN && PS2_code == last_key_q) state_d = KEY_UP;
        accept = (CAPTURE_BREAK != 0);
      end
    end
  end

  // Tracker outputs.
  always_comb begin
    Key_down = (state_q == KEY_DOWN);
  end

  // History and statistics update; Clear overrides everything else.
  always_comb begin
    history_d  = history_q;
    valid_d    = valid_q;
    new_code_d = 1'b0;
    event_d    = event_q;
    repeat_d   = repeat_q;
    drop_d     = drop_q;
    if (Clear) begin
      history_d = '0;
      valid_d   = '0;
      event_d   = '0;
      repeat_d  = '0;
      drop_d    = '0;
    end else begin
      if (suppress && repeat_q != 8'hFF) repeat_d = repeat_q + 8'd1;
      if (accept) begin
        if (Hold) begin
          if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end else begin
          history_d  = hist_shift;
          if (valid_q != VMAX) valid_d = valid_q + VW'(1);
          event_d    = event_q + 16'd1;
          new_code_d = 1'b1;
        end
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      history_q  <= '0;
      valid_q    <= '0;
      new_code_q <= 1'b0;
      event_q    <= '0;
      repeat_q   <= '0;
      drop_q     <= '0;
    end else begin
      history_q  <= history_d;
      valid_q    <= valid_d;
      new_code_q <= new_code_d;
      event_q    <= event_d;
      repeat_q   <= repeat_d;
      drop_q     <= drop_d;
    end
  end

  assign History      = history_q;
  assign Valid_count  = valid_q;
  assign New_code     = new_code_q;
  assign Event_count  = event_q;
  assign Repeat_count = repeat_q;
  assign Drop_count   = drop_q;

endmodule

// File: tb/tb_ps2_code_history.sv
// Bench for ps2_code_history: two instances share stimulus, one storing make
// codes only (A), one also storing break codes (B). A behavioural model of
// key state, a byte history and counters predicts every output each cycle.
module tb_ps2_code_history;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] code = 8'h00;
  logic       rdy = 1'b0, make = 1'b0, hold = 1'b0, clr = 1'b0;

  logic [23:0] hist_a, hist_b;
  logic [1:0]  valid_a, valid_b;
  logic        new_a, new_b, kd_a, kd_b;
  logic [15:0] evt_a, evt_b;
  logic [7:0]  rep_a, rep_b, drop_a, drop_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ps2_code_history #(.DEPTH(3), .CAPTURE_BREAK(0), .SUPPRESS_REP(1)) dut_a (
    .Clock_50(clk), .Resetn(rstn), .PS2_code(code), .PS2_code_ready(rdy),
    .PS2_make_code(make), .Hold(hold), .Clear(clr),
    .History(hist_a), .Valid_count(valid_a), .New_code(new_a), .Key_down(kd_a),
    .Event_count(evt_a), .Repeat_count(rep_a), .Drop_count(drop_a));

  ps2_code_history #(.DEPTH(3), .CAPTURE_BREAK(1), .SUPPRESS_REP(1)) dut_b (
    .Clock_50(clk), .Resetn(rstn), .PS2_code(code), .PS2_code_ready(rdy),
    .PS2_make_code(make), .Hold(hold), .Clear(clr),
    .History(hist_b), .Valid_count(valid_b), .New_code(new_b), .Key_down(kd_b),
    .Event_count(evt_b), .Repeat_count(rep_b), .Drop_count(drop_b));

  // Reference model state, index 0 = A, 1 = B.
  logic [23:0] m_hist [2];
  int          m_valid [2], m_evt [2], m_rep [2], m_drop [2];
  bit          m_new [2], m_down [2];
  logic [7:0]  m_key [2];
  bit          m_rb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_clear(input int i);
    m_hist[i] = '0; m_valid[i] = 0; m_evt[i] = 0; m_rep[i] = 0; m_drop[i] = 0;
    m_new[i] = 0; m_down[i] = 0; m_key[i] = 8'h00;
  endtask

  task automatic m_event(input int i);
    bit acc;
    bit sup;
    acc = 0; sup = 0;
    if (make) begin
      if (m_down[i] && code == m_key[i]) sup = 1;
      else begin m_down[i] = 1; m_key[i] = code; acc = 1; end
    end else begin
      if (m_down[i] && code == m_key[i]) m_down[i] = 0;
      acc = (i == 1);
    end
    if (sup) m_rep[i] = (m_rep[i] < 255) ? m_rep[i] + 1 : 255;
    else if (acc) begin
      if (hold) m_drop[i] = (m_drop[i] < 255) ? m_drop[i] + 1 : 255;
      else begin
        m_hist[i]  = {m_hist[i][15:0], code};
        m_valid[i] = (m_valid[i] < 3) ? m_valid[i] + 1 : 3;
        m_evt[i]   = (m_evt[i] + 1) % 65536;
        m_new[i]   = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("hist_a",  32'(hist_a),  32'(m_hist[0]));
    chk("valid_a", 32'(valid_a), 32'(m_valid[0]));
    chk("new_a",   32'(new_a),   32'(m_new[0]));
    chk("kd_a",    32'(kd_a),    32'(m_down[0]));
    chk("evt_a",   32'(evt_a),   32'(m_evt[0]));
    chk("rep_a",   32'(rep_a),   32'(m_rep[0]));
    chk("drop_a",  32'(drop_a),  32'(m_drop[0]));
    chk("hist_b",  32'(hist_b),  32'(m_hist[1]));
    chk("valid_b", 32'(valid_b), 32'(m_valid[1]));
    chk("new_b",   32'(new_b),   32'(m_new[1]));
    chk("kd_b",    32'(kd_b),    32'(m_down[1]));
    chk("evt_b",   32'(evt_b),   32'(m_evt[1]));
    chk("rep_b",   32'(rep_b),   32'(m_rep[1]));
    chk("drop_b",  32'(drop_b),  32'(m_drop[1]));
  endtask

  // One clock: predict with current inputs, let the edge pass, compare.
  task automatic cyc();
    bit e;
    if (!rstn) begin
      m_clear(0); m_clear(1); m_rb = 0;
    end else begin
      e = rdy && !m_rb;
      for (int i = 0; i < 2; i++) begin
        m_new[i] = 0;
        if (clr) m_clear(i);
        else if (e) m_event(i);
      end
      m_rb = rdy;
    end
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic send(input logic [7:0] c, input bit mk);
    code = c; make = mk; rdy = 1'b1; cyc();
    rdy = 1'b0; cyc();
  endtask

  task automatic do_clear();
    clr = 1'b1; cyc(); clr = 1'b0;
  endtask

  logic [7:0] codes [4];
  int ev0;

  initial begin
    codes[0] = 8'h1C; codes[1] = 8'h32; codes[2] = 8'h21; codes[3] = 8'h23;
    m_clear(0); m_clear(1); m_rb = 0;

    // Reset state
    cyc(); cyc();
    rstn = 1'b1;
    cyc();

    // Makes with breaks between
    send(8'h1C, 1); send(8'h1C, 0);
    send(8'h32, 1); send(8'h32, 0);
    send(8'h21, 1); send(8'h21, 0);
    send(8'h23, 1); send(8'h23, 0);
    chk("t1_hist",  32'(hist_a),  32'h322123);
    chk("t1_valid", 32'(valid_a), 32'd3);
    chk("t1_evt",   32'(evt_a),   32'd4);

    // Typematic repeat suppression
    do_clear();
    for (int k = 0; k < 5; k++) send(8'h1C, 1);
    chk("t2_hist", 32'(hist_a[7:0]), 32'h1C);
    chk("t2_evt",  32'(evt_a), 32'd1);
    chk("t2_rep",  32'(rep_a), 32'd4);
    chk("t2_kd1",  32'(kd_a),  32'd1);
    send(8'h1C, 0);
    chk("t2_kd0",  32'(kd_a),  32'd0);

    // Break capture on instance B
    do_clear();
    send(8'h1C, 1); send(8'h1C, 0);
    chk("t3_hist", 32'(hist_b[15:0]), 32'h1C1C);
    chk("t3_evt",  32'(evt_b), 32'd2);
    chk("t3_kd",   32'(kd_b),  32'd0);

    // Hold drops accepted codes
    do_clear();
    hold = 1'b1;
    send(8'h1C, 1); send(8'h32, 1);
    chk("t4_hist", 32'(hist_a), 32'h0);
    chk("t4_drop", 32'(drop_a), 32'd2);
    hold = 1'b0;
    send(8'h21, 1);
    chk("t4_new", 32'(hist_a[7:0]), 32'h21);

    // Clear coinciding with an event edge
    code = 8'h44; make = 1'b1; rdy = 1'b1; clr = 1'b1; cyc();
    clr = 1'b0; rdy = 1'b0; cyc();
    chk("t5_hist", 32'(hist_a), 32'h0);
    chk("t5_evt",  32'(evt_a),  32'd0);
    chk("t5_kd",   32'(kd_a),   32'd0);
    send(8'h3A, 1);
    chk("t5_first", 32'(hist_a), 32'h00003A);

    // Level held high gives a single event
    ev0 = m_evt[0];
    code = 8'h5A; make = 1'b1; rdy = 1'b1;
    repeat (100) cyc();
    rdy = 1'b0; cyc();
    chk("t6_once", 32'(evt_a), 32'(ev0 + 1));

    // Drop saturation
    hold = 1'b1;
    for (int k = 0; k < 300; k++) send(8'(k % 200 + 1), 1);
    hold = 1'b0;
    chk("t6_sat", 32'(drop_a), 32'hFF);

    // Randomized traffic
    do_clear();
    for (int n = 0; n < 600; n++) begin
      rdy  = 1'($urandom_range(0, 1));
      code = codes[$urandom_range(0, 3)];
      make = ($urandom_range(0, 9) < 7);
      hold = ($urandom_range(0, 9) < 2);
      clr  = ($urandom_range(0, 49) == 0);
      cyc();
    end
    rdy = 1'b0; hold = 1'b0; clr = 1'b0; cyc();

    // Asynchronous reset mid-operation
    send(8'h1C, 1);
    rstn = 1'b0; #1;
    m_clear(0); m_clear(1); m_rb = 0;
    check_all();
    cyc();
    rstn = 1'b1;
    send(8'h32, 1);
    chk("rst_after", 32'(hist_a), 32'h000032);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
